clk_div_gen: RTL

- Synthesisable, parametrised clock-enable/divided-clock generator with a reset stretcher. Replaces hand-written per-rate clock toggling (clk50/clk25 style) in benches and small designs.
- Produces NUM_CH independently programmable, phase-alignable divided clocks and rising-edge tick strobes from one master clock.
- Also produces a stretched, synchronously released reset for downstream logic.

---
 rtl/clk_div_pkg.sv | 6 +
 rtl/clk_div_ch.sv | 79 +++++++
 rtl/clk_div_gen.sv | 65 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider / enable generator.
package clk_div_pkg;
    localparam int DEF_CNT_W = 8;
    typedef logic [DEF_CNT_W-1:0] div_t;
    localparam div_t DEF_DIV_VAL = div_t'(1);
endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active divisor, half-period counter, toggle and tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = int'(DEF_DIV_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             sync_i,
    output logic             clk_div_o,
    output logic             tick_o
);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    always_comb begin
        shadow_d = shadow_q;
        if (load_i) begin
            shadow_d = div_i;
        end
    end

    // The active divisor only follows the shadow at a falling (period) boundary
    // or while the channel is idle, so a reload never truncates a phase.
    always_comb begin
        cnt_d    = cnt_q;
        out_d    = out_q;
        active_d = active_q;
        tick_d   = 1'b0;
        if (hold_i) begin
            cnt_d    = '0;
            out_d    = 1'b0;
            active_d = RST_DIV;
        end else if (sync_i || !en_i || (active_q == '0)) begin
            cnt_d    = '0;
            out_d    = 1'b0;
            active_d = shadow_d;
        end else if (cnt_q == active_q - ONE) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = ~out_q;
            if (out_q) begin
                active_d = shadow_d;
            end
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= RST_DIV;
            shadow_q <= RST_DIV;
        end else begin
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
        end
    end

    assign clk_div_o = out_q;
    assign tick_o    = tick_q;
endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel divided clock / tick generator with a stretched, synchronously released reset.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEF_DIV  = int'(DEF_DIV_VAL),
    parameter int RST_HOLD = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic                    load_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic                    sync_i,
    output logic [NUM_CH-1:0]       clk_div_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic                    rst_out
);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rst_out_q, rst_out_d;

    // Counts edges after rst falls; released on the RST_HOLD-th one.
    always_comb begin
        hold_d    = hold_q;
        rst_out_d = rst_out_q;
        if (rst_out_q) begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                rst_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            rst_out_q <= 1'b1;
        end else begin
            hold_q    <= hold_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign rst_out = rst_out_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .hold_i   (rst_out_q),
            .div_i    (div_i[i*CNT_W +: CNT_W]),
            .load_i   (load_i),
            .en_i     (en_i[i]),
            .sync_i   (sync_i),
            .clk_div_o(clk_div_o[i]),
            .tick_o   (tick_o[i])
        );
    end
endmodule
